cmp16_pair_sequencer: RTL and testbench



---
 rtl/cmp16_pair_sequencer.sv | 105 ++++++++++
 tb/tb_cmp16_pair_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp16_pair_sequencer.sv
// cmp16_pair_sequencer: pairs consecutive samples as (A,B), drives the
// registered magnitude comparator and returns one result code per pair.
module cmp16_pair_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [15:0]      s_data,
  output logic             s_ready,
  output logic             cmp_start,
  output logic [15:0]      cmp_ain,
  output logic [15:0]      cmp_bin,
  input  logic             cmp_greater,
  input  logic             cmp_less,
  input  logic             cmp_equal,
  input  logic             cmp_done,
  output logic             r_valid,
  output logic [1:0]       r_code,
  input  logic             r_ready,
  output logic [CNT_W-1:0] pair_cnt,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [1:0] flag_code;

  // Exactly one flag set is a valid answer; anything else is malformed.
  always_comb begin
    flag_code = 2'b00;
    unique case ({cmp_greater, cmp_less, cmp_equal})
      3'b100:  flag_code = 2'b01;
      3'b010:  flag_code = 2'b10;
      3'b001:  flag_code = 2'b11;
      default: flag_code = 2'b00;
    endcase
  end

  assign s_ready   = (state == IDLE) || (state == LOAD_B);
  assign cmp_start = (state == ISSUE);
  assign r_valid   = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmp_ain     <= '0;
      cmp_bin     <= '0;
      r_code      <= '0;
      pair_cnt    <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_valid) begin
            cmp_ain <= s_data;
            state   <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (s_valid) begin
            cmp_bin <= s_data;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (cmp_done) begin
            r_code <= flag_code;
            state  <= RESP;
          end else if (wait_cnt + 8'd1 == TO_LIM) begin
            r_code      <= 2'b00;
            err_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (r_ready) begin
            pair_cnt <= pair_cnt + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp16_pair_sequencer.sv
// tb_cmp16_pair_sequencer: random and directed pair streams checked
// against a pair/latency model; the bench also plays the comparator.
module tb_cmp16_pair_sequencer;

  localparam int TO = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [15:0]   s_data;
  logic          s_ready;
  logic          cmp_start;
  logic [15:0]   cmp_ain;
  logic [15:0]   cmp_bin;
  logic          cmp_greater;
  logic          cmp_less;
  logic          cmp_equal;
  logic          cmp_done;
  logic          r_valid;
  logic [1:0]    r_code;
  logic          r_ready;
  logic [CW-1:0] pair_cnt;
  logic          err_timeout;

  cmp16_pair_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cmp_start(cmp_start), .cmp_ain(cmp_ain), .cmp_bin(cmp_bin),
    .cmp_greater(cmp_greater), .cmp_less(cmp_less),
    .cmp_equal(cmp_equal), .cmp_done(cmp_done),
    .r_valid(r_valid), .r_code(r_code), .r_ready(r_ready),
    .pair_cnt(pair_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;
  bit sticky = 0;
  // 0 normal, 1 never done, 2 greater+less, 3 done with no flags
  int cmode = 0;
  bit force_done = 0;
  bit pend = 0;
  logic [15:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Comparator stand-in: answers in the cycle after the start pulse.
  always @(negedge clk) begin
    cmp_done = 0; cmp_greater = 0; cmp_less = 0; cmp_equal = 0;
    if (pend && cmode != 1) begin
      cmp_done = 1;
      if (cmode == 0) begin
        cmp_greater = cmp_ain > cmp_bin;
        cmp_less    = cmp_ain < cmp_bin;
        cmp_equal   = cmp_ain == cmp_bin;
      end else if (cmode == 2) begin
        cmp_greater = 1; cmp_less = 1;
      end
    end
    if (force_done) begin
      cmp_done = 1; cmp_greater = 1;
    end
    pend = cmp_start;
  end

  function automatic logic [1:0] ref_code(logic [15:0] a, logic [15:0] b, int mode);
    if (mode != 0) return 2'b00;
    if (a > b) return 2'b01;
    if (a < b) return 2'b10;
    return 2'b11;
  endfunction

  task automatic do_reset();
    rst = 1; s_valid = 1; s_data = 16'($urandom); r_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; s_valid = 0;
    model_cnt = 0; sticky = 0;
  endtask

  task automatic run_stream(input string name, input int mode,
                            input int vpct, input int rpct, input int budget);
    int idx, npairs, delivered, b_cyc, rv_from;
    bit consumed, outstanding, has_a, es, erv, acc;
    logic [15:0] a, b;
    logic [1:0] ecode;
    idx = 0; npairs = q.size() / 2; delivered = 0;
    b_cyc = 0; rv_from = 0; consumed = 1; outstanding = 0; has_a = 0;
    a = 0; b = 0; ecode = 0;
    cmode = mode;
    for (int k = 0; k < budget && delivered < npairs; k++) begin
      if (consumed || !s_valid) begin
        s_valid = (idx < q.size()) && ($urandom_range(99) < vpct);
        s_data  = (idx < q.size()) ? q[idx] : 16'h0;
      end
      r_ready = $urandom_range(99) < rpct;
      consumed = 0;
      @(negedge clk);
      if (outstanding && mode == 1 && cyc >= rv_from) sticky = 1;
      vectors++;
      if (s_ready !== !outstanding) begin
        errors++;
        $display("FAIL %s s_ready cyc %0d: got %b want %b", name, cyc, s_ready, !outstanding);
      end
      es = outstanding && (cyc == b_cyc + 1);
      vectors++;
      if (cmp_start !== es) begin
        errors++;
        $display("FAIL %s cmp_start cyc %0d: got %b want %b", name, cyc, cmp_start, es);
      end
      if (outstanding && cyc > b_cyc) begin
        vectors++;
        if (cmp_ain !== a || cmp_bin !== b) begin
          errors++;
          $display("FAIL %s operands: got %h/%h want %h/%h", name, cmp_ain, cmp_bin, a, b);
        end
      end
      erv = outstanding && cyc >= rv_from;
      vectors++;
      if (r_valid !== erv) begin
        errors++;
        $display("FAIL %s r_valid cyc %0d: got %b want %b", name, cyc, r_valid, erv);
      end
      if (erv) begin
        vectors++;
        if (r_code !== ecode) begin
          errors++;
          $display("FAIL %s r_code: got %b want %b", name, r_code, ecode);
        end
      end
      vectors++;
      if (err_timeout !== sticky || pair_cnt !== CW'(model_cnt)) begin
        errors++;
        $display("FAIL %s err/cnt: got %b/%0d want %b/%0d", name,
                 err_timeout, pair_cnt, sticky, CW'(model_cnt));
      end
      acc = s_valid && !outstanding;
      if (erv && r_ready) begin
        model_cnt = (model_cnt + 1) % (1 << CW);
        outstanding = 0;
        delivered++;
      end
      if (acc) begin
        consumed = 1;
        if (!has_a) begin
          a = s_data; has_a = 1;
        end else begin
          b = s_data; has_a = 0; outstanding = 1; b_cyc = cyc;
          rv_from = cyc + 2 + ((mode == 1) ? TO : 1);
          ecode = ref_code(a, b, mode);
        end
        idx++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (delivered < npairs) begin
      errors++;
      $display("FAIL %s budget: got %0d results want %0d", name, delivered, npairs);
    end
    s_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({s_ready, cmp_start, r_valid, err_timeout} !== 4'b1000) begin
      errors++;
      $display("FAIL reset flags: got %b want 1000", {s_ready, cmp_start, r_valid, err_timeout});
    end
    vectors++;
    if ({cmp_ain, cmp_bin, r_code, pair_cnt} !== '0) begin
      errors++;
      $display("FAIL reset data: got %h %h %b %0d want zeros", cmp_ain, cmp_bin, r_code, pair_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    q.delete(); q.push_back(16'h1234); q.push_back(16'h1000);
    run_stream("latency", 0, 100, 100, 50);
  endtask

  task automatic test_codes();
    q.delete();
    q.push_back(16'h0005); q.push_back(16'hFFFF);
    q.push_back(16'hABCD); q.push_back(16'hABCD);
    run_stream("codes", 0, 100, 100, 50);
  endtask

  task automatic test_gap();
    cmode = 0; r_ready = 1;
    s_valid = 1; s_data = 16'h0002;
    @(posedge clk); #1 s_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (s_ready !== 1'b1 || cmp_start !== 1'b0) begin
        errors++;
        $display("FAIL gap idle %0d: got %b%b want 10", i, s_ready, cmp_start);
      end
      @(posedge clk); #1;
    end
    s_valid = 1; s_data = 16'h0001;
    @(posedge clk); #1 s_valid = 0;
    @(negedge clk);
    vectors++;
    if (cmp_start !== 1'b1 || cmp_ain !== 16'h0002 || cmp_bin !== 16'h0001) begin
      errors++;
      $display("FAIL gap issue: got %b %h %h want 1 0002 0001", cmp_start, cmp_ain, cmp_bin);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (r_valid !== 1'b1 || r_code !== 2'b01) begin
      errors++;
      $display("FAIL gap result: got %b %b want 1 01", r_valid, r_code);
    end
    @(posedge clk); #1;
    model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic test_stall();
    logic [15:0] a, b;
    logic [1:0] ec;
    a = 16'($urandom); b = 16'($urandom);
    ec = ref_code(a, b, 0);
    cmode = 0; r_ready = 0;
    s_valid = 1; s_data = a;
    @(posedge clk); #1 s_data = b;
    @(posedge clk); #1 s_data = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({r_valid, r_code, s_ready, cmp_start} !== {1'b1, ec, 2'b00}) begin
        errors++;
        $display("FAIL stall hold %0d: got %b want %b", i,
                 {r_valid, r_code, s_ready, cmp_start}, {1'b1, ec, 2'b00});
      end
      @(posedge clk); #1;
    end
    r_ready = 1; s_valid = 0;
    @(posedge clk); #1;
    model_cnt = (model_cnt + 1) % (1 << CW);
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1 || r_valid !== 1'b0 || pair_cnt !== CW'(model_cnt) || cmp_bin !== b) begin
      errors++;
      $display("FAIL stall release: got %b %b %0d %h want 1 0 %0d %h",
               s_ready, r_valid, pair_cnt, cmp_bin, CW'(model_cnt), b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] a;
    q.delete();
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      q.push_back(a);
      q.push_back(($urandom_range(3) == 0) ? a : 16'($urandom));
    end
    run_stream("random", 0, 60, 50, 800);
  endtask

  task automatic test_malformed();
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(16'($urandom));
    run_stream("malformed2", 2, 80, 80, 200);
    q.delete();
    for (int i = 0; i < 2; i++) q.push_back(16'($urandom));
    run_stream("malformed0", 3, 80, 80, 100);
  endtask

  task automatic test_timeout();
    q.delete();
    for (int i = 0; i < 2; i++) q.push_back(16'($urandom));
    run_stream("timeout", 1, 100, 100, 100);
    q.delete();
    q.push_back(16'h8000 | 16'($urandom));
    q.push_back(16'h7FFF & 16'($urandom));
    run_stream("after_timeout", 0, 100, 100, 100);
    q.delete();
    for (int i = 0; i < 2; i++) q.push_back(16'($urandom));
    run_stream("malformed_sticky", 2, 100, 100, 100);
  endtask

  task automatic test_rst_wait();
    cmode = 1; r_ready = 1;
    s_valid = 1; s_data = 16'($urandom);
    @(posedge clk); #1 s_data = 16'($urandom);
    @(posedge clk); #1 s_valid = 0;
    @(negedge clk);
    vectors++;
    if (cmp_start !== 1'b1) begin
      errors++;
      $display("FAIL rstwait issue: got %b want 1", cmp_start);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; force_done = 1;
    model_cnt = 0; sticky = 0;
    @(negedge clk);
    vectors++;
    if ({s_ready, cmp_start, cmp_ain, cmp_bin, r_valid, r_code, pair_cnt, err_timeout}
        !== {1'b1, 39'b0}) begin
      errors++;
      $display("FAIL rstwait outputs: got %b %b %h %h %b %b %0d %b want 1 0 0 0 0 0 0 0",
               s_ready, cmp_start, cmp_ain, cmp_bin, r_valid, r_code, pair_cnt, err_timeout);
    end
    @(posedge clk); #1 force_done = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({r_valid, cmp_start, s_ready, err_timeout} !== 4'b0010) begin
        errors++;
        $display("FAIL rstwait late_done %0d: got %b want 0010", i,
                 {r_valid, cmp_start, s_ready, err_timeout});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(16'($urandom));
    run_stream("wrap", 0, 80, 80, 600);
    @(negedge clk);
    vectors++;
    if (pair_cnt !== 2'd1) begin
      errors++;
      $display("FAIL wrap pair_cnt: got %0d want 1", pair_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; s_valid = 0; s_data = 0; r_ready = 0;
    test_reset();
    test_latency();
    test_codes();
    test_gap();
    test_stall();
    test_random();
    test_malformed();
    test_timeout();
    test_rst_wait();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
